// File: rtl/rep_window_scheduler.sv
// Round-robin window scheduler sharing one repetition engine between NUM_REQ streams.
// Optional idle timeout in RUN is compiled in with `define REP_SCHED_TIMEOUT_EN.
module rep_window_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int FIELD_SIZE   = 16,
    parameter int MAX_WIN_LOG2 = 10,
    parameter int DRAIN_CYCLES = 2,
    parameter int TIMEOUT      = 256
) (
    input  logic                                 sys_clk,
    input  logic                                 reset_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*FIELD_SIZE-1:0]        req_field,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic                                 cfg_enable,
    input  logic [$clog2(MAX_WIN_LOG2+1)-1:0]    cfg_win_log2,
    input  logic [FIELD_SIZE-1:0]                cfg_threshold,
    output logic                                 eng_valid,
    output logic [FIELD_SIZE-1:0]                eng_field,
    output logic                                 eng_clear,
    input  logic [FIELD_SIZE-1:0]                eng_rep_rate,
    output logic                                 res_valid,
    output logic [$clog2(NUM_REQ)-1:0]           res_id,
    output logic [FIELD_SIZE-1:0]                res_count,
    output logic                                 res_found,
    output logic                                 res_partial
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int LOG_W   = $clog2(MAX_WIN_LOG2 + 1);
    localparam int CNT_W   = MAX_WIN_LOG2 + 1;
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    if (NUM_REQ < 2 || DRAIN_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("rep_window_scheduler: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         owner_q, owner_d;
    logic [ID_W-1:0]         rr_q, rr_d;
    logic [CNT_W-1:0]        win_last_q, win_last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DRAIN_W-1:0]      drain_q, drain_d;
    logic                    partial_q, partial_d;
    logic                    eng_valid_q, eng_valid_d;
    logic [FIELD_SIZE-1:0]   eng_field_q, eng_field_d;
    logic                    eng_clear_q, eng_clear_d;
    logic                    res_valid_q, res_valid_d;
    logic [ID_W-1:0]         res_id_q, res_id_d;
    logic [FIELD_SIZE-1:0]   res_count_q, res_count_d;
    logic                    res_found_q, res_found_d;
    logic                    res_partial_q, res_partial_d;

    logic [2*NUM_REQ-1:0]    rot_s;
    logic [ID_W-1:0]         grant_s;
    logic [ID_W-1:0]         rr_next_s;
    logic [LOG_W-1:0]        log_eff_s;
    logic [FIELD_SIZE-1:0]   owner_field_s;
    logic                    xfer_s;
    logic                    last_s;
    logic                    capture_s;
    logic                    timeout_s;

    assign rot_s         = {req_valid, req_valid} >> rr_q;
    assign rr_next_s     = (owner_q == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : owner_q + ID_W'(1);
    assign log_eff_s     = (cfg_win_log2 > LOG_W'(MAX_WIN_LOG2)) ? LOG_W'(MAX_WIN_LOG2) : cfg_win_log2;
    assign owner_field_s = req_field[owner_q*FIELD_SIZE +: FIELD_SIZE];
    assign xfer_s        = (state_q == S_RUN) & req_valid[owner_q];
    assign last_s        = xfer_s & (cnt_q == win_last_q);
    assign capture_s     = (state_q == S_DRAIN) & (drain_q == DRAIN_W'(DRAIN_CYCLES - 1));

`ifdef REP_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] idle_q, idle_d;

    assign timeout_s = (state_q == S_RUN) & ~xfer_s & (idle_q == TO_W'(TIMEOUT - 1));
    assign idle_d    = (state_q == S_RUN && !xfer_s) ? idle_q + TO_W'(1) : {TO_W{1'b0}};

    // Idle-cycle counter for the forced close of a stalled window
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= {TO_W{1'b0}};
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // First valid requester at or after the round-robin pointer; lowest offset wins
    always_comb begin
        int pos;
        grant_s = rr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos     = (int'(rr_q) + k >= NUM_REQ) ? int'(rr_q) + k - NUM_REQ : int'(rr_q) + k;
            grant_s = rot_s[k] ? ID_W'(pos) : grant_s;
        end
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            owner_q       <= {ID_W{1'b0}};
            rr_q          <= {ID_W{1'b0}};
            win_last_q    <= {CNT_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            drain_q       <= {DRAIN_W{1'b0}};
            partial_q     <= 1'b0;
            eng_valid_q   <= 1'b0;
            eng_field_q   <= {FIELD_SIZE{1'b0}};
            eng_clear_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_id_q      <= {ID_W{1'b0}};
            res_count_q   <= {FIELD_SIZE{1'b0}};
            res_found_q   <= 1'b0;
            res_partial_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_q          <= rr_d;
            win_last_q    <= win_last_d;
            cnt_q         <= cnt_d;
            drain_q       <= drain_d;
            partial_q     <= partial_d;
            eng_valid_q   <= eng_valid_d;
            eng_field_q   <= eng_field_d;
            eng_clear_q   <= eng_clear_d;
            res_valid_q   <= res_valid_d;
            res_id_q      <= res_id_d;
            res_count_q   <= res_count_d;
            res_found_q   <= res_found_d;
            res_partial_q <= res_partial_d;
        end
    end

    // Window sequencing: grant, sample counting, drain countdown
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        win_last_d = win_last_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        partial_d  = partial_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_enable && (|req_valid)) begin
                    state_d    = S_RUN;
                    owner_d    = grant_s;
                    win_last_d = (CNT_W'(1) << log_eff_s) - CNT_W'(1);
                    cnt_d      = {CNT_W{1'b0}};
                    partial_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (xfer_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_s) begin
                        state_d = S_DRAIN;
                        drain_d = {DRAIN_W{1'b0}};
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (timeout_s) begin
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        state_d   = S_DRAIN;
                        drain_d   = {DRAIN_W{1'b0}};
                        partial_d = 1'b1;
                    end else begin
                        // Nothing was forwarded: give the slot away without a result
                        state_d = S_IDLE;
                        rr_d    = rr_next_s;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (capture_s) begin
                    state_d = S_IDLE;
                    rr_d    = rr_next_s;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Engine strobes, result capture and the owner's ready
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (state_q == S_RUN) begin
            req_ready[owner_q] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
        eng_valid_d   = xfer_s;
        eng_field_d   = xfer_s ? owner_field_s : eng_field_q;
        eng_clear_d   = last_s | (timeout_s & (cnt_q != {CNT_W{1'b0}}));
        res_valid_d   = capture_s;
        res_id_d      = capture_s ? owner_q : res_id_q;
        res_count_d   = capture_s ? eng_rep_rate : res_count_q;
        res_found_d   = capture_s ? (eng_rep_rate >= cfg_threshold) : res_found_q;
        res_partial_d = capture_s ? partial_q : res_partial_q;
    end

    assign eng_valid   = eng_valid_q;
    assign eng_field   = eng_field_q;
    assign eng_clear   = eng_clear_q;
    assign res_valid   = res_valid_q;
    assign res_id      = res_id_q;
    assign res_count   = res_count_q;
    assign res_found   = res_found_q;
    assign res_partial = res_partial_q;

endmodule

// File: tb/tb_rep_window_scheduler.sv
// Scoreboard bench for rep_window_scheduler: random sources, a behavioural window model
// feeding expectation queues, and a monitor that checks every engine beat and result.
module tb_rep_window_scheduler;

    localparam int NUM_REQ = 4;
    localparam int FS      = 16;
    localparam int MAXL    = 10;
    localparam int D       = 2;
    localparam int TIMEOUT = 256;

    logic                     sys_clk;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*FS-1:0]    req_field;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     cfg_enable;
    logic [3:0]               cfg_win_log2;
    logic [FS-1:0]            cfg_threshold;
    logic                     eng_valid;
    logic [FS-1:0]            eng_field;
    logic                     eng_clear;
    logic [FS-1:0]            eng_rep_rate;
    logic                     res_valid;
    logic [1:0]               res_id;
    logic [FS-1:0]            res_count;
    logic                     res_found;
    logic                     res_partial;

    rep_window_scheduler #(
        .NUM_REQ(NUM_REQ), .FIELD_SIZE(FS), .MAX_WIN_LOG2(MAXL),
        .DRAIN_CYCLES(D), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk(sys_clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_field(req_field), .req_ready(req_ready),
        .cfg_enable(cfg_enable), .cfg_win_log2(cfg_win_log2), .cfg_threshold(cfg_threshold),
        .eng_valid(eng_valid), .eng_field(eng_field), .eng_clear(eng_clear),
        .eng_rep_rate(eng_rep_rate),
        .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
        .res_found(res_found), .res_partial(res_partial)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed { logic valid; logic clear; logic [FS-1:0] field; } beat_t;
    typedef struct packed { logic [1:0] id; logic [FS-1:0] count; logic found; logic partial; } res_t;

    beat_t        exp_beats[$];
    res_t         exp_res[$];
    int           got_ids[$];
    int           beats_seen;
    logic [FS-1:0] src_q [NUM_REQ][$];
    int           src_prob [NUM_REQ];
    int           n_checks;
    int           n_errors;

    // Reference model: window phase 0=idle, 1=collecting, 2=draining
    int           m_phase, m_owner, m_rr, m_len, m_cnt, m_idle, m_dcnt;
    bit           m_partial;
    logic [NUM_REQ-1:0] m_exp_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        beat_t b;
        res_t  r;
        logic [NUM_REQ-1:0] one;
        if (!reset_n) begin
            m_phase = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_idle = 0; m_dcnt = 0;
            m_partial = 1'b0;
            exp_beats.delete();
            exp_res.delete();
        end else begin
            case (m_phase)
                0: if (cfg_enable && req_valid != '0) begin
                    for (int k = NUM_REQ - 1; k >= 0; k--) begin
                        if (req_valid[(m_rr + k) % NUM_REQ]) m_owner = (m_rr + k) % NUM_REQ;
                    end
                    m_len = 1 << ((int'(cfg_win_log2) > MAXL) ? MAXL : int'(cfg_win_log2));
                    m_cnt = 0; m_idle = 0; m_partial = 1'b0; m_phase = 1;
                end
                1: if (req_valid[m_owner]) begin
                    b.valid = 1'b1;
                    b.clear = (m_cnt == m_len - 1);
                    b.field = req_field[m_owner*FS +: FS];
                    exp_beats.push_back(b);
                    m_cnt++; m_idle = 0;
                    if (b.clear) begin m_phase = 2; m_dcnt = 0; end
                end else begin
                    m_idle++;
`ifdef REP_SCHED_TIMEOUT_EN
                    if (m_idle == TIMEOUT) begin
                        if (m_cnt > 0) begin
                            b.valid = 1'b0; b.clear = 1'b1; b.field = '0;
                            exp_beats.push_back(b);
                            m_partial = 1'b1; m_phase = 2; m_dcnt = 0;
                        end else begin
                            m_rr = (m_owner + 1) % NUM_REQ; m_phase = 0;
                        end
                    end
`endif
                end
                default: if (m_dcnt == D - 1) begin
                    r.id = 2'(m_owner); r.count = eng_rep_rate;
                    r.found = (eng_rep_rate >= cfg_threshold); r.partial = m_partial;
                    exp_res.push_back(r);
                    m_rr = (m_owner + 1) % NUM_REQ; m_phase = 0;
                end else begin
                    m_dcnt++;
                end
            endcase
        end
        one = 4'b0001;
        m_exp_ready = (m_phase == 1) ? (one << m_owner) : '0;
    endtask

    task automatic monitor_step();
        beat_t b;
        res_t  r;
        check("req_ready", 32'(req_ready), 32'(m_exp_ready));
        check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        if (eng_valid || eng_clear) begin
            beats_seen++;
            if (exp_beats.size() == 0) begin
                check("unexpected_eng_beat", {eng_valid, eng_clear}, 32'd0);
            end else begin
                b = exp_beats.pop_front();
                check("eng_valid", 32'(eng_valid), 32'(b.valid));
                check("eng_clear", 32'(eng_clear), 32'(b.clear));
                if (b.valid) check("eng_field", 32'(eng_field), 32'(b.field));
            end
        end
        if (exp_beats.size() != 0) begin
            check("missing_eng_beat", 32'(exp_beats.size()), 32'd0);
            exp_beats.delete();
        end
        if (res_valid) begin
            got_ids.push_back(int'(res_id));
            if (exp_res.size() == 0) begin
                check("unexpected_res_valid", 32'(res_valid), 32'd0);
            end else begin
                r = exp_res.pop_front();
                check("res_id", 32'(res_id), 32'(r.id));
                check("res_count", 32'(res_count), 32'(r.count));
                check("res_found", 32'(res_found), 32'(r.found));
                check("res_partial", 32'(res_partial), 32'(r.partial));
            end
        end
        if (exp_res.size() != 0) begin
            check("missing_res_valid", 32'(exp_res.size()), 32'd0);
            exp_res.delete();
        end
    endtask

    initial forever begin
        @(posedge sys_clk);
        model_step();
    end

    initial forever begin
        @(posedge sys_clk);
        #1;
        if (reset_n) monitor_step();
    end

    // Sources: present the head of each queue with a per-requester probability
    initial begin
        req_valid    = '0;
        req_field    = '0;
        eng_rep_rate = '0;
        forever begin
            @(negedge sys_clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (src_q[i].size() > 0 && $urandom_range(0, 99) < src_prob[i]) begin
                    req_valid[i] = 1'b1;
                    req_field[i*FS +: FS] = src_q[i][0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_field[i*FS +: FS] = 16'($urandom);
                end
            end
            eng_rep_rate = 16'($urandom);
            #4;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic push_src(input int i, input int n, input int prob);
        src_prob[i] = prob;
        for (int k = 0; k < n; k++) src_q[i].push_back(16'($urandom));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int cyc;
        bit done;
        cyc = 0; done = 1'b0;
        while (!done && cyc < budget) begin
            @(negedge sys_clk);
            cyc++;
            done = (m_phase == 0);
            for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) done = 1'b0;
        end
        if (!done) check({name, "_wait_timeout"}, 32'(cyc), 32'(budget + 1));
    endtask

    task automatic wait_phase(input string name, input int ph, input int budget);
        int cyc;
        cyc = 0;
        while (m_phase != ph && cyc < budget) begin
            @(negedge sys_clk);
            cyc++;
        end
        if (m_phase != ph) check({name, "_phase_timeout"}, 32'(m_phase), 32'(ph));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ready"}, 32'(req_ready), 32'd0);
        check({name, "_eng"}, {eng_valid, eng_clear, eng_field}, 32'd0);
        check({name, "_res"}, {res_valid, res_found, res_partial, res_id, res_count}, 32'd0);
    endtask

    initial begin
        int base_res, base_beats, cyc, exp_partial_cnt;
        n_checks = 0; n_errors = 0; beats_seen = 0;
        for (int i = 0; i < NUM_REQ; i++) src_prob[i] = 100;
        reset_n = 1'b0; cfg_enable = 1'b0; cfg_win_log2 = 4'd0; cfg_threshold = 16'd0;
        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Requester 0 alone, four fixed samples
        cfg_enable = 1'b1; cfg_win_log2 = 4'd2; cfg_threshold = 16'h8000;
        base_res = got_ids.size(); base_beats = beats_seen;
        src_prob[0] = 100;
        src_q[0].push_back(16'd5); src_q[0].push_back(16'd5);
        src_q[0].push_back(16'd7); src_q[0].push_back(16'd9);
        wait_idle("t1", 200);
        repeat (4) @(negedge sys_clk);
        check("t1_beats", 32'(beats_seen - base_beats), 32'd4);
        check("t1_results", 32'(got_ids.size() - base_res), 32'd1);
        if (got_ids.size() > base_res) check("t1_id", 32'(got_ids[base_res]), 32'd0);

        // Requesters 1 and 3 contend with two-sample windows
        cfg_win_log2 = 4'd1;
        base_res = got_ids.size();
        push_src(1, 4, 100); push_src(3, 4, 100);
        wait_idle("t2", 200);
        repeat (4) @(negedge sys_clk);
        check("t2_results", 32'(got_ids.size() - base_res), 32'd4);
        if (got_ids.size() >= base_res + 4) begin
            check("t2_order0", 32'(got_ids[base_res]),     32'd1);
            check("t2_order1", 32'(got_ids[base_res + 1]), 32'd3);
            check("t2_order2", 32'(got_ids[base_res + 2]), 32'd1);
            check("t2_order3", 32'(got_ids[base_res + 3]), 32'd3);
        end

        // One-sample windows from every requester
        cfg_win_log2 = 4'd0;
        base_res = got_ids.size();
        for (int i = 0; i < NUM_REQ; i++) push_src(i, 5, 70);
        wait_idle("t3", 1000);
        repeat (4) @(negedge sys_clk);
        check("t3_results", 32'(got_ids.size() - base_res), 32'd20);

        // Owner stalls 300 cycles halfway through a four-sample window
        cfg_win_log2 = 4'd2;
        base_res = got_ids.size();
        push_src(0, 2, 100);
        cyc = 0;
        while (src_q[0].size() != 0 && cyc < 100) begin @(negedge sys_clk); cyc++; end
        repeat (300) @(negedge sys_clk);
        push_src(0, 2, 100);
`ifdef REP_SCHED_TIMEOUT_EN
        exp_partial_cnt = 2;
        cyc = 0;
        while (src_q[0].size() != 0 && cyc < 100) begin @(negedge sys_clk); cyc++; end
        repeat (300) @(negedge sys_clk);
`else
        exp_partial_cnt = 1;
`endif
        wait_idle("t4", 2000);
        repeat (4) @(negedge sys_clk);
        check("t4_results", 32'(got_ids.size() - base_res), 32'(exp_partial_cnt));

        // Reset while draining aborts the window and restarts arbitration at 0
        cfg_win_log2 = 4'd1;
        base_res = got_ids.size();
        push_src(2, 2, 100);
        wait_phase("t5", 2, 100);
        reset_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        check_all_zero("t5_reset");
        check("t5_no_result", 32'(got_ids.size() - base_res), 32'd0);
        reset_n = 1'b1;
        @(negedge sys_clk);
        push_src(3, 2, 100); push_src(0, 2, 100);
        wait_idle("t5b", 300);
        repeat (4) @(negedge sys_clk);
        check("t5_results", 32'(got_ids.size() - base_res), 32'd2);
        if (got_ids.size() > base_res) check("t5_first_id", 32'(got_ids[base_res]), 32'd0);

        // Enable dropped mid-window: window reports, then nothing is granted
        cfg_win_log2 = 4'd3;
        base_res = got_ids.size();
        push_src(2, 8, 60);
        wait_phase("t6", 1, 100);
        cfg_enable = 1'b0;
        push_src(1, 3, 100);
        cyc = 0;
        while ((m_phase != 0 || src_q[2].size() != 0) && cyc < 500) begin @(negedge sys_clk); cyc++; end
        repeat (20) @(negedge sys_clk);
        check("t6_results", 32'(got_ids.size() - base_res), 32'd1);
        check("t6_ready_held", 32'(req_ready), 32'd0);
        check("t6_pending", 32'(src_q[1].size()), 32'd3);
        cfg_win_log2 = 4'd0;
        cfg_enable = 1'b1;
        wait_idle("t6b", 300);

        // Randomised traffic, window length fixed per round
        for (int it = 0; it < 40; it++) begin
            cfg_win_log2  = 4'($urandom_range(0, 3));
            cfg_threshold = 16'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 1) == 1)
                    push_src(i, $urandom_range(1, 2) << cfg_win_log2, $urandom_range(50, 100));
            end
            wait_idle("rand", 3000);
        end
        repeat (6) @(negedge sys_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
